eth_rx_frame_ctrl: RTL and testbench



---
 rtl/eth_rx_frame_ctrl_if.sv | 58 +++++
 rtl/eth_rx_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : eth_rx_frame_ctrl_if
// Brief   : RX stream, parser strobes, config, status handshake and counters
// Rev     : 1.0  initial release
// ============================================================================
interface eth_rx_frame_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 11
);
  // GMII stream and parser side
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             is_dst_mac;
  logic             is_payload_or_crc;
  logic             err_preamble_sfd;
  logic             err_incomplete;
  logic             crc_ok;

  // Configuration
  logic             cfg_enable;
  logic             cfg_promisc;
  logic             cfg_accept_bcast;
  logic [47:0]      cfg_mac_addr;

  // Payload gate and status handshake
  logic             payload_keep;
  logic             stat_valid;
  logic             stat_ready;
  logic             stat_accept;
  logic [2:0]       stat_reason;
  logic [LEN_W-1:0] stat_len;

  // Statistics
  logic [CNT_W-1:0] cnt_rx_ok;
  logic [CNT_W-1:0] cnt_drop_filter;
  logic [CNT_W-1:0] cnt_drop_err;
  logic [CNT_W-1:0] cnt_drop_ovf;

  modport master (
    output rx_valid, rx_data, is_dst_mac, is_payload_or_crc,
    output err_preamble_sfd, err_incomplete, crc_ok,
    output cfg_enable, cfg_promisc, cfg_accept_bcast, cfg_mac_addr,
    output stat_ready,
    input  payload_keep, stat_valid, stat_accept, stat_reason, stat_len,
    input  cnt_rx_ok, cnt_drop_filter, cnt_drop_err, cnt_drop_ovf
  );

  modport slave (
    input  rx_valid, rx_data, is_dst_mac, is_payload_or_crc,
    input  err_preamble_sfd, err_incomplete, crc_ok,
    input  cfg_enable, cfg_promisc, cfg_accept_bcast, cfg_mac_addr,
    input  stat_ready,
    output payload_keep, stat_valid, stat_accept, stat_reason, stat_len,
    output cnt_rx_ok, cnt_drop_filter, cnt_drop_err, cnt_drop_ovf
  );
endinterface
`default_nettype wire

// File: rtl/eth_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : eth_rx_frame_ctrl
// Brief   : Per-frame RX controller: DA filter, payload gate, status, stats
// Rev     : 1.0  initial release
// ============================================================================
module eth_rx_frame_ctrl #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 11
) (
  input  wire                clk,
  input  wire                rst,
  eth_rx_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_BODY    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [2:0] C_RSN_OK   = 3'd0;
  localparam logic [2:0] C_RSN_FILT = 3'd1;
  localparam logic [2:0] C_RSN_PRE  = 3'd2;
  localparam logic [2:0] C_RSN_INC  = 3'd3;
  localparam logic [2:0] C_RSN_CRC  = 3'd4;

  state_t           state_q;
  logic             rx_valid_q;
  logic [47:0]      dst_q;
  logic             match_q;
  logic             err_pre_q;
  logic             err_inc_q;
  logic [LEN_W-1:0] len_q;

  logic             stat_valid_q;
  logic             stat_accept_q;
  logic [2:0]       stat_reason_q;
  logic [LEN_W-1:0] stat_len_q;
  logic [CNT_W-1:0] cnt_ok_q;
  logic [CNT_W-1:0] cnt_filt_q;
  logic [CNT_W-1:0] cnt_err_q;
  logic [CNT_W-1:0] cnt_ovf_q;

  logic             frame_start;
  logic             in_frame;
  logic             frame_end;
  logic             dst_match;
  logic             load_word;
  logic [2:0]       end_reason;

  assign frame_start = bus.rx_valid & ~rx_valid_q;
  assign in_frame    = (state_q == S_HDR) | (state_q == S_BODY);
  assign frame_end   = in_frame & ~bus.rx_valid;

  assign dst_match = bus.cfg_promisc
                   | (dst_q == bus.cfg_mac_addr)
                   | (bus.cfg_accept_bcast & (&dst_q));

  // The status slot accepts a new word when empty or being drained this cycle.
  assign load_word = frame_end & (~stat_valid_q | bus.stat_ready);

  // Error pulses arriving in the end cycle still count for this frame.
  always_comb begin
    end_reason = C_RSN_OK;
    if (err_pre_q | bus.err_preamble_sfd) begin
      end_reason = C_RSN_PRE;
    end else if (err_inc_q | bus.err_incomplete) begin
      end_reason = C_RSN_INC;
    end else if (!bus.crc_ok) begin
      end_reason = C_RSN_CRC;
    end else if ((state_q == S_HDR) || !match_q) begin
      end_reason = C_RSN_FILT;
    end
  end

  assign bus.payload_keep = (state_q == S_BODY) & bus.rx_valid & bus.is_payload_or_crc
                          & match_q & ~err_pre_q & ~err_inc_q;

  // Frame-tracking state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_valid_q <= 1'b1;
      dst_q      <= '0;
      match_q    <= 1'b0;
      err_pre_q  <= 1'b0;
      err_inc_q  <= 1'b0;
      len_q      <= '0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q   <= bus.cfg_enable ? S_HDR : S_DISCARD;
            dst_q     <= '0;
            match_q   <= 1'b0;
            err_pre_q <= 1'b0;
            err_inc_q <= 1'b0;
            len_q     <= '0;
          end
        end
        S_HDR: begin
          if (!bus.rx_valid) begin
            state_q <= S_IDLE;
          end else if (bus.is_dst_mac) begin
            dst_q <= {dst_q[39:0], bus.rx_data};
          end else begin
            state_q <= S_BODY;
            match_q <= dst_match;
          end
        end
        S_BODY: begin
          if (!bus.rx_valid) begin
            state_q <= S_IDLE;
          end else if (bus.is_payload_or_crc && !(&len_q)) begin
            len_q <= len_q + 1'b1;
          end
        end
        S_DISCARD: begin
          if (!bus.rx_valid) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (in_frame) begin
        if (bus.err_preamble_sfd) err_pre_q <= 1'b1;
        if (bus.err_incomplete)   err_inc_q <= 1'b1;
      end
    end
  end

  // Single-entry status register and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid_q  <= 1'b0;
      stat_accept_q <= 1'b0;
      stat_reason_q <= '0;
      stat_len_q    <= '0;
      cnt_ok_q      <= '0;
      cnt_filt_q    <= '0;
      cnt_err_q     <= '0;
      cnt_ovf_q     <= '0;
    end else begin
      if (load_word) begin
        stat_valid_q  <= 1'b1;
        stat_accept_q <= (end_reason == C_RSN_OK);
        stat_reason_q <= end_reason;
        stat_len_q    <= len_q;
        case (end_reason)
          C_RSN_OK:   if (!(&cnt_ok_q))   cnt_ok_q   <= cnt_ok_q + 1'b1;
          C_RSN_FILT: if (!(&cnt_filt_q)) cnt_filt_q <= cnt_filt_q + 1'b1;
          default:    if (!(&cnt_err_q))  cnt_err_q  <= cnt_err_q + 1'b1;
        endcase
      end else begin
        if (stat_valid_q && bus.stat_ready) begin
          stat_valid_q <= 1'b0;
        end
        if (frame_end && !(&cnt_ovf_q)) begin
          cnt_ovf_q <= cnt_ovf_q + 1'b1;
        end
      end
    end
  end

  assign bus.stat_valid      = stat_valid_q;
  assign bus.stat_accept     = stat_accept_q;
  assign bus.stat_reason     = stat_reason_q;
  assign bus.stat_len        = stat_len_q;
  assign bus.cnt_rx_ok       = cnt_ok_q;
  assign bus.cnt_drop_filter = cnt_filt_q;
  assign bus.cnt_drop_err    = cnt_err_q;
  assign bus.cnt_drop_ovf    = cnt_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_rx_frame_ctrl
// Brief   : Scenario tasks plus randomized frames against a frame-level model
// Rev     : 1.0  initial release
// ============================================================================
module tb_eth_rx_frame_ctrl;

  localparam int          CNT_W   = 2;
  localparam int          LEN_W   = 11;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam int          LEN_MAX = (1 << LEN_W) - 1;
  localparam logic [47:0] OWN_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct packed {
    logic             acc;
    logic [2:0]       rsn;
    logic [LEN_W-1:0] len;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_rx_frame_ctrl_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  eth_rx_frame_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  int    keep_cnt = 0;
  word_t obs_q[$];

  always @(negedge clk) begin
    if (!rst && bus.stat_valid && bus.stat_ready)
      obs_q.push_back({bus.stat_accept, bus.stat_reason, bus.stat_len});
    if (bus.payload_keep) keep_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic dm, input logic pc);
    bus.rx_valid          = v;
    bus.rx_data           = d;
    bus.is_dst_mac        = dm;
    bus.is_payload_or_crc = pc;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.err_preamble_sfd = 1'b0;
    bus.err_incomplete   = 1'b0;
    bus.crc_ok           = 1'b0;
    bus.cfg_enable       = 1'b1;
    bus.cfg_promisc      = 1'b0;
    bus.cfg_accept_bcast = 1'b0;
    bus.cfg_mac_addr     = OWN_MAC;
    bus.stat_ready       = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    obs_q.delete();
    keep_cnt = 0;
  endtask

  // One start byte, 6 DA bytes, 8 SA/type bytes, npay payload+FCS bytes, end cycle.
  // hdr_cut >= 0 drops rx_valid after that many DA bytes.
  task automatic send_frame(input logic [47:0] dst, input int npay, input bit pre_err,
                            input bit inc_end, input bit crc, input int hdr_cut);
    keep_cnt = 0;
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == hdr_cut) break;
      drive(1'b1, dst[47-8*k -: 8], 1'b1, 1'b0);
      tick();
    end
    if (hdr_cut < 0) begin
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        bus.err_preamble_sfd = pre_err && (k == 2);
        tick();
      end
      bus.err_preamble_sfd = 1'b0;
      for (int k = 0; k < npay; k++) begin
        drive(1'b1, 8'($urandom), 1'b0, 1'b1);
        tick();
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.crc_ok         = crc;
    bus.err_incomplete = inc_end;
    tick();
    bus.crc_ok         = 1'b0;
    bus.err_incomplete = 1'b0;
  endtask

  function automatic bit addr_ok(input logic [47:0] dst, input bit promisc, input bit bcast);
    return promisc || (dst == OWN_MAC) || (bcast && (dst == BCAST));
  endfunction

  function automatic word_t model_word(input logic [47:0] dst, input int npay, input bit pre_err,
                                       input bit inc_end, input bit crc, input int hdr_cut,
                                       input bit promisc, input bit bcast);
    word_t w;
    int    r;
    bit    cut = (hdr_cut >= 0);
    if (pre_err)                                   r = 2;
    else if (inc_end)                              r = 3;
    else if (!crc)                                 r = 4;
    else if (cut || !addr_ok(dst, promisc, bcast)) r = 1;
    else                                           r = 0;
    w.acc = (r == 0);
    w.rsn = 3'(r);
    w.len = cut ? '0 : LEN_W'((npay > LEN_MAX) ? LEN_MAX : npay);
    return w;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    drive(1'b1, 8'hAA, 1'b0, 1'b1);
    tick();
    tick();
    n_checks++; if (bus.payload_keep !== 1'b0) $display("FAIL reset_keep: got %b expected 0", bus.payload_keep); else n_pass++;
    n_checks++; if (bus.stat_valid !== 1'b0) $display("FAIL reset_stat_valid: got %b expected 0", bus.stat_valid); else n_pass++;
    n_checks++;
    if ({bus.stat_accept, bus.stat_reason, bus.stat_len} !== '0)
      $display("FAIL reset_stat_word: got %h expected 0", {bus.stat_accept, bus.stat_reason, bus.stat_len});
    else n_pass++;
    n_checks++;
    if ({bus.cnt_rx_ok, bus.cnt_drop_filter, bus.cnt_drop_err, bus.cnt_drop_ovf} !== '0)
      $display("FAIL reset_counters: got %h expected 0",
               {bus.cnt_rx_ok, bus.cnt_drop_filter, bus.cnt_drop_err, bus.cnt_drop_ovf});
    else n_pass++;
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(OWN_MAC, 50, 1'b0, 1'b0, 1'b1, -1);
    n_checks++; if (keep_cnt !== 50) $display("FAIL good_keep: got %0d expected 50", keep_cnt); else n_pass++;
    n_checks++; if (bus.stat_valid !== 1'b1) $display("FAIL good_stat_valid: got %b expected 1", bus.stat_valid); else n_pass++;
    n_checks++;
    if ({bus.stat_accept, bus.stat_reason, bus.stat_len} !== {1'b1, 3'd0, 11'd50})
      $display("FAIL good_word: got acc=%b rsn=%0d len=%0d expected acc=1 rsn=0 len=50",
               bus.stat_accept, bus.stat_reason, bus.stat_len);
    else n_pass++;
    n_checks++; if (bus.cnt_rx_ok !== 2'd1) $display("FAIL good_cnt_ok: got %0d expected 1", bus.cnt_rx_ok); else n_pass++;
    tick();
    n_checks++; if (bus.stat_valid !== 1'b0) $display("FAIL good_valid_fall: got %b expected 0", bus.stat_valid); else n_pass++;
    n_checks++; if (obs_q.size() !== 1) $display("FAIL good_transfers: got %0d expected 1", obs_q.size()); else n_pass++;
  endtask

  task automatic test_filtering();
    do_reset();
    send_frame(48'h02_00_00_00_00_02, 20, 1'b0, 1'b0, 1'b1, -1);
    n_checks++; if (keep_cnt !== 0) $display("FAIL filt_keep: got %0d expected 0", keep_cnt); else n_pass++;
    n_checks++; if (bus.stat_reason !== 3'd1) $display("FAIL filt_reason: got %0d expected 1", bus.stat_reason); else n_pass++;
    n_checks++; if (bus.cnt_drop_filter !== 2'd1) $display("FAIL filt_cnt: got %0d expected 1", bus.cnt_drop_filter); else n_pass++;
    bus.cfg_promisc = 1'b1;
    send_frame(48'h02_00_00_00_00_02, 20, 1'b0, 1'b0, 1'b1, -1);
    n_checks++; if (bus.stat_reason !== 3'd0) $display("FAIL promisc_reason: got %0d expected 0", bus.stat_reason); else n_pass++;
    n_checks++; if (keep_cnt !== 20) $display("FAIL promisc_keep: got %0d expected 20", keep_cnt); else n_pass++;
    bus.cfg_promisc      = 1'b0;
    bus.cfg_accept_bcast = 1'b1;
    send_frame(BCAST, 20, 1'b0, 1'b0, 1'b1, -1);
    n_checks++; if (bus.stat_reason !== 3'd0) $display("FAIL bcast_reason: got %0d expected 0", bus.stat_reason); else n_pass++;
    bus.cfg_accept_bcast = 1'b0;
    send_frame(BCAST, 20, 1'b0, 1'b0, 1'b1, -1);
    n_checks++; if (bus.stat_reason !== 3'd1) $display("FAIL bcast_off_reason: got %0d expected 1", bus.stat_reason); else n_pass++;
    n_checks++;
    if (bus.cnt_rx_ok !== 2'd2 || bus.cnt_drop_filter !== 2'd2)
      $display("FAIL filt_totals: got ok=%0d filt=%0d expected ok=2 filt=2", bus.cnt_rx_ok, bus.cnt_drop_filter);
    else n_pass++;
  endtask

  task automatic test_error_priority();
    do_reset();
    send_frame(OWN_MAC, 20, 1'b1, 1'b0, 1'b0, -1);
    n_checks++; if (bus.stat_reason !== 3'd2) $display("FAIL pre_reason: got %0d expected 2", bus.stat_reason); else n_pass++;
    n_checks++; if (keep_cnt !== 0) $display("FAIL pre_keep: got %0d expected 0", keep_cnt); else n_pass++;
    n_checks++; if (bus.cnt_drop_err !== 2'd1) $display("FAIL pre_cnt: got %0d expected 1", bus.cnt_drop_err); else n_pass++;
    send_frame(OWN_MAC, 0, 1'b0, 1'b1, 1'b0, 3);
    n_checks++; if (bus.stat_reason !== 3'd3) $display("FAIL inc_reason: got %0d expected 3", bus.stat_reason); else n_pass++;
    send_frame(OWN_MAC, 10, 1'b0, 1'b0, 1'b0, -1);
    n_checks++; if (bus.stat_reason !== 3'd4) $display("FAIL crc_reason: got %0d expected 4", bus.stat_reason); else n_pass++;
    n_checks++; if (bus.stat_accept !== 1'b0) $display("FAIL crc_accept: got %b expected 0", bus.stat_accept); else n_pass++;
  endtask

  task automatic test_backpressure();
    word_t held;
    do_reset();
    bus.stat_ready = 1'b0;
    send_frame(OWN_MAC, 20, 1'b0, 1'b0, 1'b1, -1);
    held = {bus.stat_accept, bus.stat_reason, bus.stat_len};
    n_checks++; if (held !== {1'b1, 3'd0, 11'd20}) $display("FAIL bp_first_word: got %h expected %h", held, {1'b1, 3'd0, 11'd20}); else n_pass++;
    send_frame(OWN_MAC, 30, 1'b0, 1'b0, 1'b1, -1);
    tick();
    tick();
    n_checks++;
    if (bus.stat_valid !== 1'b1 || {bus.stat_accept, bus.stat_reason, bus.stat_len} !== held)
      $display("FAIL bp_hold: got valid=%b word=%h expected valid=1 word=%h", bus.stat_valid,
               {bus.stat_accept, bus.stat_reason, bus.stat_len}, held);
    else n_pass++;
    n_checks++; if (bus.cnt_drop_ovf !== 2'd1) $display("FAIL bp_ovf: got %0d expected 1", bus.cnt_drop_ovf); else n_pass++;
    n_checks++; if (bus.cnt_rx_ok !== 2'd1) $display("FAIL bp_cnt_ok: got %0d expected 1", bus.cnt_rx_ok); else n_pass++;
    bus.stat_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.stat_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", bus.stat_valid); else n_pass++;
    n_checks++; if (obs_q.size() !== 1) $display("FAIL bp_transfers: got %0d expected 1", obs_q.size()); else n_pass++;
  endtask

  task automatic test_enable();
    do_reset();
    bus.cfg_enable = 1'b0;
    send_frame(OWN_MAC, 20, 1'b0, 1'b0, 1'b1, -1);
    tick();
    n_checks++; if (keep_cnt !== 0) $display("FAIL dis_keep: got %0d expected 0", keep_cnt); else n_pass++;
    n_checks++;
    if (obs_q.size() !== 0 || bus.stat_valid !== 1'b0)
      $display("FAIL dis_status: got transfers=%0d valid=%b expected 0/0", obs_q.size(), bus.stat_valid);
    else n_pass++;
    n_checks++;
    if ({bus.cnt_rx_ok, bus.cnt_drop_filter, bus.cnt_drop_err, bus.cnt_drop_ovf} !== '0)
      $display("FAIL dis_counters: got %h expected 0",
               {bus.cnt_rx_ok, bus.cnt_drop_filter, bus.cnt_drop_err, bus.cnt_drop_ovf});
    else n_pass++;
    bus.cfg_enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.stat_ready = 1'b0;
    send_frame(OWN_MAC, 12, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, OWN_MAC[47-8*k -: 8], 1'b1, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    keep_cnt = 0;
    bus.stat_ready = 1'b1;
    for (int k = 3; k < 6; k++) begin
      drive(1'b1, OWN_MAC[47-8*k -: 8], 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < 28; k++) begin
      drive(1'b1, 8'($urandom), 1'b0, k >= 8);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.crc_ok = 1'b1;
    tick();
    bus.crc_ok = 1'b0;
    tick();
    n_checks++; if (keep_cnt !== 0) $display("FAIL rstmid_keep: got %0d expected 0", keep_cnt); else n_pass++;
    n_checks++;
    if (obs_q.size() !== 0 || bus.stat_valid !== 1'b0)
      $display("FAIL rstmid_status: got transfers=%0d valid=%b expected 0/0", obs_q.size(), bus.stat_valid);
    else n_pass++;
    n_checks++; if (bus.cnt_rx_ok !== 2'd0) $display("FAIL rstmid_cnt: got %0d expected 0", bus.cnt_rx_ok); else n_pass++;
    send_frame(OWN_MAC, 16, 1'b0, 1'b0, 1'b1, -1);
    n_checks++;
    if ({bus.stat_valid, bus.stat_accept, bus.stat_reason, bus.stat_len} !== {1'b1, 1'b1, 3'd0, 11'd16})
      $display("FAIL rstmid_next_word: got v=%b acc=%b rsn=%0d len=%0d expected 1/1/0/16",
               bus.stat_valid, bus.stat_accept, bus.stat_reason, bus.stat_len);
    else n_pass++;
    n_checks++; if (keep_cnt !== 16) $display("FAIL rstmid_next_keep: got %0d expected 16", keep_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send_frame(OWN_MAC, 2100, 1'b0, 1'b0, 1'b1, -1);
      n_checks++; if (bus.stat_len !== 11'd2047) $display("FAIL sat_len%0d: got %0d expected 2047", f, bus.stat_len); else n_pass++;
      n_checks++; if (keep_cnt !== 2100) $display("FAIL sat_keep%0d: got %0d expected 2100", f, keep_cnt); else n_pass++;
    end
    n_checks++; if (bus.cnt_rx_ok !== 2'd3) $display("FAIL sat_cnt_ok: got %0d expected 3", bus.cnt_rx_ok); else n_pass++;
  endtask

  task automatic test_back_to_back();
    word_t exp_q[$];
    int    m_ok = 0, m_filt = 0, m_err = 0;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      logic [47:0] dst;
      int  npay, cut;
      bit  pre, inc, crc, prom, bc, en;
      word_t w;
      case ($urandom_range(0, 3))
        0, 1:    dst = OWN_MAC;
        2:       dst = BCAST;
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      npay = $urandom_range(0, 40);
      cut  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : -1;
      pre  = (cut < 0) && ($urandom_range(0, 5) == 0);
      inc  = ($urandom_range(0, 5) == 0);
      crc  = ($urandom_range(0, 5) != 0);
      prom = ($urandom_range(0, 3) == 0);
      bc   = $urandom_range(0, 1) == 1;
      en   = ($urandom_range(0, 7) != 0);
      bus.cfg_promisc      = prom;
      bus.cfg_accept_bcast = bc;
      bus.cfg_enable       = en;
      send_frame(dst, npay, pre, inc, crc, cut);
      begin
        int exp_keep = (en && cut < 0 && !pre && addr_ok(dst, prom, bc)) ? npay : 0;
        n_checks++; if (keep_cnt !== exp_keep) $display("FAIL b2b_keep%0d: got %0d expected %0d", f, keep_cnt, exp_keep); else n_pass++;
      end
      if (en) begin
        w = model_word(dst, npay, pre, inc, crc, cut, prom, bc);
        exp_q.push_back(w);
        if (w.rsn == 3'd0)      m_ok   = sat_inc(m_ok);
        else if (w.rsn == 3'd1) m_filt = sat_inc(m_filt);
        else                    m_err  = sat_inc(m_err);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    tick();
    tick();
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL b2b_word%0d: got acc=%b rsn=%0d len=%0d expected acc=%b rsn=%0d len=%0d", i,
                 obs_q[i].acc, obs_q[i].rsn, obs_q[i].len, exp_q[i].acc, exp_q[i].rsn, exp_q[i].len);
      else n_pass++;
    end
    n_checks++;
    if (bus.cnt_rx_ok !== CNT_W'(m_ok) || bus.cnt_drop_filter !== CNT_W'(m_filt) ||
        bus.cnt_drop_err !== CNT_W'(m_err) || bus.cnt_drop_ovf !== '0)
      $display("FAIL b2b_counters: got ok=%0d filt=%0d err=%0d ovf=%0d expected %0d/%0d/%0d/0",
               bus.cnt_rx_ok, bus.cnt_drop_filter, bus.cnt_drop_err, bus.cnt_drop_ovf, m_ok, m_filt, m_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_filtering();
    test_error_priority();
    test_backpressure();
    test_enable();
    test_reset_mid_frame();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
